// File: rtl/sound_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sound_pkg                                                    |
// | Description : Shared definitions for the tone sequencer: note codes, tone  |
// |               half-period divisors, song_sel encodings, the sequencer      |
// |               state type and the song ROM lookup.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sound_pkg;

    // Note codes (3 bit)
    localparam logic [2:0] NOTE_REST  = 3'd0;
    localparam logic [2:0] NOTE_1     = 3'd1;
    localparam logic [2:0] NOTE_2     = 3'd2;
    localparam logic [2:0] NOTE_3     = 3'd3;
    localparam logic [2:0] NOTE_4     = 3'd4;
    localparam logic [2:0] NOTE_5     = 3'd5;
    localparam logic [2:0] NOTE_REST2 = 3'd6;
    localparam logic [2:0] NOTE_END   = 3'd7;

    // Half-period divisors: the counter runs 0..DIV, so a half-period is DIV+1 cycles
    localparam int unsigned DIV_1 = 38662;
    localparam int unsigned DIV_2 = 43472;
    localparam int unsigned DIV_3 = 34456;
    localparam int unsigned DIV_4 = 51588;
    localparam int unsigned DIV_5 = 28960;

    // song_sel encodings
    localparam logic [1:0] SEL_SILENT = 2'd0;
    localparam logic [1:0] SEL_GAME   = 2'd1;
    localparam logic [1:0] SEL_WIN    = 2'd2;
    localparam logic [1:0] SEL_LOSE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Song storage: one octal digit per step, step 0 is the leftmost digit.
    // Unused steps are padded with END (7).
    localparam int unsigned ROM_LEN = 64;
    localparam logic [ROM_LEN*3-1:0] GAME_ROM =
        192'o1234543213_5024103521_4325112345_4123053214_7777777777_7777777777_7777;
    localparam logic [ROM_LEN*3-1:0] WIN_ROM =
        192'o1353135524_4213531352_5542135313_4215432_7777777777_7777777777_7777777;
    localparam logic [ROM_LEN*3-1:0] LOSE_ROM =
        192'o5312_7777777777_7777777777_7777777777_7777777777_7777777777_7777777777;

    function automatic logic is_tone(input logic [2:0] note);
        return (note >= NOTE_1) && (note <= NOTE_5);
    endfunction

    function automatic int unsigned note_div(input logic [2:0] note);
        case (note)
            NOTE_1:  return DIV_1;
            NOTE_2:  return DIV_2;
            NOTE_3:  return DIV_3;
            NOTE_4:  return DIV_4;
            NOTE_5:  return DIV_5;
            default: return 0;
        endcase
    endfunction

    // Steps past the end of storage read as END so a sequencer with a
    // longer step range still terminates cleanly.
    function automatic logic [2:0] song_rom(input logic [1:0] song, input int unsigned step);
        logic [ROM_LEN*3-1:0] rom;
        if (step >= ROM_LEN) begin
            return NOTE_END;
        end
        case (song)
            SEL_GAME: rom = GAME_ROM;
            SEL_WIN:  rom = WIN_ROM;
            SEL_LOSE: rom = LOSE_ROM;
            default:  rom = '0;
        endcase
        return rom[(ROM_LEN-1-step)*3 +: 3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_gen                                                     |
// | Description : Square-wave generator for one voice. A counter runs 0..DIV   |
// |               for the current note and the output toggles at each wrap.    |
// |               A rest or a change of note restarts the counter and forces   |
// |               the output low in that same cycle.                           |
// | Ports       : clk, rst_n (async, active low), note (3-bit code), out       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tone_gen #(
    parameter int DIV_W = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] note,
    output logic       out
);
    import sound_pkg::*;

    logic [2:0]       note_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_eff;
    logic [DIV_W-1:0] div;
    logic             tog;
    logic             tog_eff;
    logic             tone;
    logic             restart;

    // The restart cycle is treated as count 0, so the first half-period of a
    // new note is DIV+1 cycles just like every later one.
    always_comb begin
        tone    = is_tone(note);
        div     = DIV_W'(note_div(note));
        restart = !tone || (note != note_q);
        cnt_eff = restart ? '0 : cnt;
        tog_eff = restart ? 1'b0 : tog;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q <= NOTE_REST;
            cnt    <= '0;
            tog    <= 1'b0;
        end else begin
            note_q <= note;
            if (!tone) begin
                cnt <= '0;
                tog <= 1'b0;
            end else if (cnt_eff == div) begin
                cnt <= '0;
                tog <= ~tog_eff;
            end else begin
                cnt <= cnt_eff + DIV_W'(1);
                tog <= tog_eff;
            end
        end
    end

    assign out = tog_eff;

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_sequencer                                               |
// | Description : Multi-voice buzzer driver. Voice 0 sounds a fixed-length     |
// |               key click; voice 1 plays the song chosen by song_sel (looping |
// |               game music or one-shot win/lose jingles); higher voices rest. |
// | Ports       : clk, rst_n (async, active low), key_pressed (async level),   |
// |               song_sel[1:0], mute, buzzer[N_VOICES-1:0], busy, song_done   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tone_sequencer #(
    parameter int MS_CYCLES   = 27000,
    parameter int STEP_CYCLES = 8200000,
    parameter int CLICK_MS    = 100,
    parameter int N_VOICES    = 2,
    parameter int DIV_W       = 17,
    parameter int SONG_LEN    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_pressed,
    input  logic [1:0]          song_sel,
    input  logic                mute,
    output logic [N_VOICES-1:0] buzzer,
    output logic                busy,
    output logic                song_done
);
    import sound_pkg::*;

    localparam int MS_W    = $clog2(MS_CYCLES + 1);
    localparam int TIMER_W = $clog2(STEP_CYCLES + 1);
    localparam int CLICK_W = $clog2(CLICK_MS + 1);
    localparam int STEP_W  = $clog2(SONG_LEN);

    // ---------------- 1 ms tick ----------------
    logic [MS_W-1:0] ms_cnt;
    logic            ms_tick;

    assign ms_tick = (ms_cnt == MS_W'(MS_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_tick ? '0 : ms_cnt + MS_W'(1);
        end
    end

    // ---------------- key click ----------------
    logic               key_meta;
    logic               key_sync;
    logic               key_prev;
    logic               key_rise;
    logic               click_on;
    logic [CLICK_W-1:0] click_cnt;
    logic [2:0]         click_note;

    assign key_rise   = key_sync & ~key_prev;
    assign click_note = click_on ? NOTE_1 : NOTE_REST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            key_prev  <= 1'b0;
            click_on  <= 1'b0;
            click_cnt <= '0;
        end else begin
            key_meta <= key_pressed;
            key_sync <= key_meta;
            key_prev <= key_sync;
            // A fresh press restarts the duration even if a tick lands in the same cycle
            if (key_rise) begin
                click_on  <= 1'b1;
                click_cnt <= '0;
            end else if (click_on && ms_tick) begin
                if (click_cnt == CLICK_W'(CLICK_MS - 1)) begin
                    click_on  <= 1'b0;
                    click_cnt <= '0;
                end else begin
                    click_cnt <= click_cnt + CLICK_W'(1);
                end
            end
        end
    end

    // ---------------- song sequencer ----------------
    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [1:0]          sel_q;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_nxt;
    logic [STEP_W-1:0]   step_inc;
    logic [TIMER_W-1:0]  step_cnt;
    logic                step_tick;
    logic                sel_change;
    logic                song_end;
    logic                timer_clr;
    logic                done_nxt;
    logic [2:0]          song_note;

    // END is detected on the step being advanced to, so a looping song jumps
    // straight back to step 0 and END is never presented to a voice.
    always_comb begin
        sel_change = (song_sel != sel_q);
        step_tick  = (state == ST_PLAY) && (step_cnt == TIMER_W'(STEP_CYCLES - 1));
        step_inc   = step + STEP_W'(1);
        song_end   = (step == STEP_W'(SONG_LEN - 1)) ||
                     (song_rom(sel_q, 32'(step_inc)) == NOTE_END);

        state_nxt = state;
        step_nxt  = step;
        timer_clr = 1'b0;
        done_nxt  = 1'b0;

        if (sel_change) begin
            state_nxt = (song_sel == SEL_SILENT) ? ST_IDLE : ST_PLAY;
            step_nxt  = '0;
            timer_clr = 1'b1;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (step_tick) begin
                        if (!song_end) begin
                            step_nxt = step_inc;
                        end else if (sel_q == SEL_GAME) begin
                            step_nxt = '0;
                        end else begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy      = (state == ST_PLAY);
        song_note = (state == ST_PLAY) ? song_rom(sel_q, 32'(step)) : NOTE_REST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= SEL_SILENT;
            step      <= '0;
            song_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= song_sel;
            step      <= step_nxt;
            song_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (timer_clr || (step_cnt == TIMER_W'(STEP_CYCLES - 1))) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + TIMER_W'(1);
        end
    end

    // ---------------- voices ----------------
    // Songs carry a single track, so only voice 1 sounds it; further voices rest.
    generate
        for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
            logic [2:0] vnote;
            logic       vout;
            if (v == 0) begin : g_click
                assign vnote = click_note;
            end else if (v == 1) begin : g_song
                assign vnote = song_note;
            end else begin : g_rest
                assign vnote = NOTE_REST;
            end
            tone_gen #(
                .DIV_W (DIV_W)
            ) u_tone (
                .clk   (clk),
                .rst_n (rst_n),
                .note  (vnote),
                .out   (vout)
            );
            assign buzzer[v] = vout & ~mute;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tone_sequencer                                            |
// | Description : Directed self-checking bench. A short-timing instance covers |
// |               click timing and song sequencing; a long-step instance holds |
// |               one note long enough to observe a tone edge, mute and reset. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic       mute = 1'b0;
    logic [1:0] buzzer;
    logic       busy;
    logic       song_done;

    logic       rst_n_l = 1'b0;
    logic       key_l = 1'b0;
    logic [1:0] song_sel_l = 2'd0;
    logic       mute_l = 1'b0;
    logic [1:0] buzzer_l;
    logic       busy_l;
    logic       song_done_l;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // posedges since reset release; the DUT's ms counter follows cyc % 10
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    tone_sequencer #(
        .MS_CYCLES(10), .STEP_CYCLES(100), .CLICK_MS(5),
        .N_VOICES(2), .DIV_W(17), .SONG_LEN(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_pressed(key), .song_sel(song_sel),
        .mute(mute), .buzzer(buzzer), .busy(busy), .song_done(song_done)
    );

    tone_sequencer #(
        .MS_CYCLES(10), .STEP_CYCLES(40000), .CLICK_MS(5),
        .N_VOICES(2), .DIV_W(17), .SONG_LEN(64)
    ) dut_long (
        .clk(clk), .rst_n(rst_n_l), .key_pressed(key_l), .song_sel(song_sel_l),
        .mute(mute_l), .buzzer(buzzer_l), .busy(busy_l), .song_done(song_done_l)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Press aligned so the synchronized edge coincides with an ms tick; the
    // click then lasts exactly CLICK_MS*MS_CYCLES = 50 cycles (80 with a
    // re-press 30 cycles later).
    task automatic run_click(input bit second, output int total, output int first);
        total = 0;
        first = -1;
        while (cyc % 10 != 7) @(negedge clk);
        for (int i = 0; i < 120; i++) begin
            key = second ? ((i < 5) || (i >= 30 && i < 35)) : (i < 60);
            if (dut.click_on) begin
                total++;
                if (first < 0) first = i;
            end
            @(negedge clk);
        end
        key = 1'b0;
    endtask

    initial begin
        int total, first, errs, busy_errs, done_cnt, done_at, mute_errs, n;
        int lose_notes[4] = '{5, 3, 1, 2};

        repeat (3) @(negedge clk);
        check_val("reset_buzzer", buzzer, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", song_done, 0);
        rst_n   = 1'b1;
        rst_n_l = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- click ----------------
        run_click(1'b0, total, first);
        check_val("click_latency", first, 3);
        check_val("click_len_held", total, 50);
        check_val("click_buzzer0_low", buzzer[0], 0);
        run_click(1'b1, total, first);
        check_val("click_len_repress", total, 80);
        check_val("click_idle_after", dut.click_on, 0);

        // ---------------- game song, mute window, change to win at step 17 ----------------
        song_sel = 2'd1;
        @(negedge clk);
        check_val("game_busy", busy, 1);
        check_val("game_step0", dut.step, 0);
        errs = 0; busy_errs = 0; done_cnt = 0; mute_errs = 0;
        for (int i = 0; i < 5800; i++) begin
            mute = (i >= 1000 && i < 1600);
            if (dut.step != (i / 100) % 40) errs++;
            if (!busy) busy_errs++;
            if (song_done) done_cnt++;
            if (mute && buzzer != 2'b00) mute_errs++;
            if (i == 3999) check_val("game_step39", dut.step, 39);
            if (i == 4000) check_val("game_wrap_step0", dut.step, 0);
            if (i == 5799) begin
                check_val("game_step17", dut.step, 17);
                song_sel = 2'd2;   // same cycle as the step tick: the change must win
            end
            @(negedge clk);
        end
        mute = 1'b0;
        check_val("game_step_errors", errs, 0);
        check_val("game_busy_errors", busy_errs, 0);
        check_val("game_no_done", done_cnt, 0);
        check_val("game_mute_errors", mute_errs, 0);

        // ---------------- win song to completion ----------------
        check_val("win_step0", dut.step, 0);
        check_val("win_first_note", dut.song_note, 1);
        errs = 0; busy_errs = 0; done_cnt = 0; done_at = -1;
        for (int j = 0; j < 3800; j++) begin
            if (j < 3700 && dut.step != j / 100) errs++;
            if (busy != (j < 3700)) busy_errs++;
            if (song_done) begin done_cnt++; done_at = j; end
            if (j == 99)  check_val("win_timer_restart", dut.step, 0);
            if (j == 100) check_val("win_step1", dut.step, 1);
            @(negedge clk);
        end
        check_val("win_step_errors", errs, 0);
        check_val("win_busy_errors", busy_errs, 0);
        check_val("win_done_count", done_cnt, 1);
        check_val("win_done_at", done_at, 3700);

        song_sel = 2'd0;
        @(negedge clk);
        check_val("idle_busy", busy, 0);
        @(negedge clk);

        // ---------------- lose song ----------------
        song_sel = 2'd3;
        @(negedge clk);
        errs = 0; busy_errs = 0; done_cnt = 0; done_at = -1; mute_errs = 0;
        for (int i = 0; i < 600; i++) begin
            if (dut.song_note != ((i < 400) ? lose_notes[i / 100] : 0)) errs++;
            if (busy != (i < 400)) busy_errs++;
            if (song_done) begin done_cnt++; done_at = i; end
            if (i >= 400 && buzzer[1] != 1'b0) mute_errs++;
            if (i % 100 == 50 && i < 400)
                check_val($sformatf("lose_note%0d", i / 100), dut.song_note, lose_notes[i / 100]);
            @(negedge clk);
        end
        check_val("lose_note_errors", errs, 0);
        check_val("lose_busy_errors", busy_errs, 0);
        check_val("lose_done_count", done_cnt, 1);
        check_val("lose_done_at", done_at, 400);
        check_val("lose_buzzer1_silent", mute_errs, 0);

        // ---------------- long instance: tone edge, mute, async reset ----------------
        song_sel_l = 2'd3;
        n = 0;
        while (!busy_l && n < 10) begin @(negedge clk); n++; end
        check_val("long_busy", busy_l, 1);
        n = 0;
        while (!buzzer_l[1] && n < 30000) begin @(negedge clk); n++; end
        check_val("long_first_half_period", n, 28961);
        mute_l = 1'b1;
        #1;
        check_val("long_mute_buzzer", buzzer_l, 0);
        check_val("long_mute_busy", busy_l, 1);
        mute_l = 1'b0;
        #1;
        check_val("long_unmute_buzzer1", buzzer_l[1], 1);
        rst_n_l = 1'b0;
        #1;
        check_val("long_reset_buzzer", buzzer_l, 0);
        check_val("long_reset_busy", busy_l, 0);
        check_val("long_reset_done", song_done_l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
